wb_axil_bridge_n: RTL and testbench



---
 rtl/wb_axil_bridge_n.sv | 200 ++++++++++++++++++++
 tb/tb_wb_axil_bridge_n.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_axil_bridge_n.sv
// Wishbone classic slave to NPORTS AXI-Lite masters with address decode, one
// outstanding transaction, timeout and protocol-safe drain of abandoned requests.
module wb_axil_bridge_n #(
  parameter int                   AW        = 32,
  parameter int                   NPORTS    = 2,
  parameter logic [NPORTS*AW-1:0] BASE_ADDR = {32'h0001_0000, 32'h0000_0000},
  parameter logic [NPORTS*AW-1:0] ADDR_MASK = {32'hFFFF_0000, 32'hFFFF_0000},
  parameter int                   TIMEOUT   = 1024
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [AW-1:0]        wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  input  logic [3:0]           wb_sel_i,
  output logic                 wb_ack_o,
  output logic [31:0]          wb_dat_o,
  output logic                 wb_err_o,
  output logic [NPORTS*AW-1:0] m_axi_awaddr,
  output logic [NPORTS*3-1:0]  m_axi_awprot,
  output logic [NPORTS-1:0]    m_axi_awvalid,
  input  logic [NPORTS-1:0]    m_axi_awready,
  output logic [NPORTS*32-1:0] m_axi_wdata,
  output logic [NPORTS*4-1:0]  m_axi_wstrb,
  output logic [NPORTS-1:0]    m_axi_wvalid,
  input  logic [NPORTS-1:0]    m_axi_wready,
  input  logic [NPORTS*2-1:0]  m_axi_bresp,
  input  logic [NPORTS-1:0]    m_axi_bvalid,
  output logic [NPORTS-1:0]    m_axi_bready,
  output logic [NPORTS*AW-1:0] m_axi_araddr,
  output logic [NPORTS*3-1:0]  m_axi_arprot,
  output logic [NPORTS-1:0]    m_axi_arvalid,
  input  logic [NPORTS-1:0]    m_axi_arready,
  input  logic [NPORTS*32-1:0] m_axi_rdata,
  input  logic [NPORTS*2-1:0]  m_axi_rresp,
  input  logic [NPORTS-1:0]    m_axi_rvalid,
  output logic [NPORTS-1:0]    m_axi_rready,
  output logic                 busy_o,
  output logic                 timeout_o
);

  localparam int SW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE, DRAIN} state_t;

  state_t         r_state, w_next;
  logic [SW-1:0]  r_port, w_port;
  logic           w_hit;
  logic           r_we, r_abort;
  logic           r_aw_pend, r_w_pend, r_ar_pend, r_rsp_pend;
  logic [1:0]     r_resp;
  logic [CW-1:0]  r_cnt;
  logic [31:0]    r_rdata;
  logic [AW-1:0]  r_addr  [NPORTS];
  logic [31:0]    r_wdata [NPORTS];
  logic [3:0]     r_wstrb [NPORTS];

  logic w_start, w_active, w_timeout, w_abort, w_pend_left;
  logic w_bready, w_rready, w_awh, w_wh, w_arh, w_bh, w_rh;
  logic [1:0]  w_bresp, w_rresp;
  logic [31:0] w_rdata;

  // Lowest matching index wins: scan downwards so the last hit assigned is the smallest.
  // NOTE: combinational blocks assign every output a default first and use blocking
  // '=', so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_hit  = 1'b0;
    w_port = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if ((wb_adr_i & ADDR_MASK[i*AW +: AW]) == BASE_ADDR[i*AW +: AW]) begin
        w_hit  = 1'b1;
        w_port = SW'(i);
      end
    end
  end

  assign w_start   = wb_cyc_i && wb_stb_i;
  assign w_active  = (r_state == WADDR) || (r_state == WRESP) ||
                     (r_state == RADDR) || (r_state == RDATA);
  assign w_timeout = w_active && (r_cnt == CW'(TIMEOUT));
  assign w_abort   = r_abort || !wb_cyc_i;

  assign w_bready = r_we  && ((r_state == WRESP) || (r_state == DRAIN));
  assign w_rready = !r_we && ((r_state == RDATA) || (r_state == DRAIN));
  assign w_awh    = r_aw_pend && m_axi_awready[r_port];
  assign w_wh     = r_w_pend  && m_axi_wready[r_port];
  assign w_arh    = r_ar_pend && m_axi_arready[r_port];
  assign w_bh     = w_bready  && m_axi_bvalid[r_port];
  assign w_rh     = w_rready  && m_axi_rvalid[r_port];
  assign w_bresp  = m_axi_bresp[2*r_port +: 2];
  assign w_rresp  = m_axi_rresp[2*r_port +: 2];
  assign w_rdata  = m_axi_rdata[32*r_port +: 32];

  // Anything still owed by either side after this cycle keeps the drain going.
  assign w_pend_left = (r_aw_pend && !w_awh) || (r_w_pend && !w_wh) ||
                       (r_ar_pend && !w_arh) || (r_rsp_pend && !(w_bh || w_rh));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_start) w_next = !w_hit ? DONE : (wb_we_i ? WADDR : RADDR);
      WADDR: if (w_timeout) w_next = DRAIN;
             else if ((!r_aw_pend || w_awh) && (!r_w_pend || w_wh)) w_next = WRESP;
      WRESP: if (w_timeout) w_next = DRAIN; else if (w_bh) w_next = DONE;
      RADDR: if (w_timeout) w_next = DRAIN; else if (w_arh) w_next = RDATA;
      RDATA: if (w_timeout) w_next = DRAIN; else if (w_rh) w_next = DONE;
      DONE:  w_next = IDLE;
      DRAIN: if (!w_pend_left) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign wb_ack_o  = (r_state == DONE) && (r_resp == 2'b00) && !w_abort;
  assign wb_err_o  = (((r_state == DONE) && (r_resp != 2'b00)) || w_timeout) && !w_abort;
  assign timeout_o = w_timeout;
  assign busy_o    = (r_state != IDLE);
  assign wb_dat_o  = r_rdata;

  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    assign m_axi_awaddr[g*AW +: AW] = r_addr[g];
    assign m_axi_araddr[g*AW +: AW] = r_addr[g];
    assign m_axi_awprot[g*3 +: 3]   = 3'b000;
    assign m_axi_arprot[g*3 +: 3]   = 3'b000;
    assign m_axi_wdata[g*32 +: 32]  = r_wdata[g];
    assign m_axi_wstrb[g*4 +: 4]    = r_wstrb[g];
    assign m_axi_awvalid[g] = r_aw_pend && (r_port == SW'(g));
    assign m_axi_wvalid[g]  = r_w_pend  && (r_port == SW'(g));
    assign m_axi_arvalid[g] = r_ar_pend && (r_port == SW'(g));
    assign m_axi_bready[g]  = w_bready  && (r_port == SW'(g));
    assign m_axi_rready[g]  = w_rready  && (r_port == SW'(g));
  end

  // NOTE: state is updated with non-blocking '<=' only, so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= IDLE;
      r_port     <= '0;
      r_we       <= 1'b0;
      r_abort    <= 1'b0;
      r_aw_pend  <= 1'b0;
      r_w_pend   <= 1'b0;
      r_ar_pend  <= 1'b0;
      r_rsp_pend <= 1'b0;
      r_resp     <= 2'b00;
      r_cnt      <= '0;
      r_rdata    <= '0;
      // NOTE: the per-port arrays are a handful of flops driving outputs directly,
      // not a RAM, so they are reset to keep the AXI buses defined after reset.
      for (int i = 0; i < NPORTS; i++) begin
        r_addr[i]  <= '0;
        r_wdata[i] <= '0;
        r_wstrb[i] <= '0;
      end
    end else begin
      r_state <= w_next;

      if (r_state == IDLE)  r_cnt <= '0;
      else if (w_active)    r_cnt <= r_cnt + 1'b1;

      if (w_awh)        r_aw_pend  <= 1'b0;
      if (w_wh)         r_w_pend   <= 1'b0;
      if (w_arh)        r_ar_pend  <= 1'b0;
      if (w_bh || w_rh) r_rsp_pend <= 1'b0;

      // Responses seen while draining are discarded.
      if (w_bh && (r_state == WRESP)) r_resp <= w_bresp;
      if (w_rh && (r_state == RDATA)) begin
        r_resp  <= w_rresp;
        r_rdata <= w_rdata;
      end

      if (r_state == IDLE) begin
        if (w_start) begin
          r_we    <= wb_we_i;
          r_abort <= 1'b0;
          r_port  <= w_port;
          if (w_hit) begin
            r_addr[w_port]  <= wb_adr_i;
            r_wdata[w_port] <= wb_dat_i;
            r_wstrb[w_port] <= wb_sel_i;
            r_aw_pend       <= wb_we_i;
            r_w_pend        <= wb_we_i;
            r_ar_pend       <= !wb_we_i;
            r_rsp_pend      <= 1'b1;
            r_resp          <= 2'b00;
          end else begin
            r_resp <= 2'b11;
          end
        end
      end else if (!wb_cyc_i) begin
        r_abort <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_axil_bridge_n.sv
// Directed bench for wb_axil_bridge_n: behavioural AXI-Lite slave with tunable
// delays, scoreboard of expected Wishbone completions, valid-cycle monitors.
module tb_wb_axil_bridge_n;

  localparam int NP = 2;
  localparam int AW = 32;

  logic clk_i = 1'b0;
  logic rstn_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o, wb_err_o, busy_o, timeout_o;
  logic [AW-1:0] wb_adr_i;
  logic [31:0] wb_dat_i, wb_dat_o;
  logic [3:0] wb_sel_i;
  logic [NP*AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [NP*3-1:0] m_axi_awprot, m_axi_arprot;
  logic [NP*32-1:0] m_axi_wdata, m_axi_rdata;
  logic [NP*4-1:0] m_axi_wstrb;
  logic [NP*2-1:0] m_axi_bresp, m_axi_rresp;
  logic [NP-1:0] m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [NP-1:0] m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic [NP-1:0] m_axi_rvalid, m_axi_rready;

  wb_axil_bridge_n #(.AW(AW), .NPORTS(NP), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o), .wb_err_o(wb_err_o),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  // Slave model: readies after a per-channel wait, responses after a delay.
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;
  int aw_c[NP], w_c[NP], ar_c[NP], b_c[NP], r_c[NP];
  logic [NP-1:0] aw_done, w_done, b_pend, r_pend;
  logic [NP-1:0] awh, wh, arh, bh, rh;

  assign m_axi_bresp = {NP{bresp_cfg}};
  assign m_axi_rresp = {NP{rresp_cfg}};
  assign m_axi_rdata = {NP{rdata_cfg}};
  assign awh = m_axi_awvalid & m_axi_awready;
  assign wh  = m_axi_wvalid & m_axi_wready;
  assign arh = m_axi_arvalid & m_axi_arready;
  assign bh  = m_axi_bvalid & m_axi_bready;
  assign rh  = m_axi_rvalid & m_axi_rready;

  always_comb begin
    m_axi_awready = '0;
    m_axi_wready  = '0;
    m_axi_arready = '0;
    m_axi_bvalid  = '0;
    m_axi_rvalid  = '0;
    for (int i = 0; i < NP; i++) begin
      m_axi_awready[i] = m_axi_awvalid[i] && (aw_c[i] >= aw_dly);
      m_axi_wready[i]  = m_axi_wvalid[i]  && (w_c[i]  >= w_dly);
      m_axi_arready[i] = m_axi_arvalid[i] && (ar_c[i] >= ar_dly);
      m_axi_bvalid[i]  = b_pend[i] && (b_c[i] >= b_dly);
      m_axi_rvalid[i]  = r_pend[i] && (r_c[i] >= r_dly);
    end
  end

  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      aw_done <= '0; w_done <= '0; b_pend <= '0; r_pend <= '0;
      for (int i = 0; i < NP; i++) begin
        aw_c[i] <= 0; w_c[i] <= 0; ar_c[i] <= 0; b_c[i] <= 0; r_c[i] <= 0;
      end
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (m_axi_awvalid[i]) aw_c[i] <= awh[i] ? 0 : aw_c[i] + 1;
        if (m_axi_wvalid[i])  w_c[i]  <= wh[i]  ? 0 : w_c[i] + 1;
        if (m_axi_arvalid[i]) ar_c[i] <= arh[i] ? 0 : ar_c[i] + 1;
        if (bh[i]) b_pend[i] <= 1'b0; else if (b_pend[i]) b_c[i] <= b_c[i] + 1;
        if (rh[i]) r_pend[i] <= 1'b0; else if (r_pend[i]) r_c[i] <= r_c[i] + 1;
        if ((aw_done[i] || awh[i]) && (w_done[i] || wh[i])) begin
          b_pend[i] <= 1'b1; b_c[i] <= 0; aw_done[i] <= 1'b0; w_done[i] <= 1'b0;
        end else begin
          if (awh[i]) aw_done[i] <= 1'b1;
          if (wh[i])  w_done[i]  <= 1'b1;
        end
        if (arh[i]) begin r_pend[i] <= 1'b1; r_c[i] <= 0; end
      end
    end
  end

  // Cumulative activity monitors; tests compare deltas.
  int aw_cyc[NP], w_cyc[NP], ar_cyc[NP];
  int ack_cnt = 0, err_cnt = 0, to_cnt = 0;
  always @(posedge clk_i) begin
    for (int i = 0; i < NP; i++) begin
      if (m_axi_awvalid[i]) aw_cyc[i] <= aw_cyc[i] + 1;
      if (m_axi_wvalid[i])  w_cyc[i]  <= w_cyc[i] + 1;
      if (m_axi_arvalid[i]) ar_cyc[i] <= ar_cyc[i] + 1;
    end
    if (wb_ack_o)  ack_cnt <= ack_cnt + 1;
    if (wb_err_o)  err_cnt <= err_cnt + 1;
    if (timeout_o) to_cnt  <= to_cnt + 1;
  end

  typedef struct {
    logic        is_err;
    int          lat;
    logic        chk_dat;
    logic [31:0] dat;
  } exp_t;
  exp_t sb[$];

  int n_err = 0, n_chk = 0;
  int obs_lat;
  logic obs_ack, obs_err, obs_to;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One Wishbone cycle; latency counts cycles from the strobe cycle (cycle 0).
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel);
    @(posedge clk_i); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    obs_lat = -1; obs_ack = 1'b0; obs_err = 1'b0; obs_to = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_i);
      if (wb_ack_o || wb_err_o) begin
        obs_lat = c; obs_ack = wb_ack_o; obs_err = wb_err_o; obs_to = timeout_o;
        break;
      end
    end
    @(posedge clk_i); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    check({tag, "_sbdepth"}, 64'(sb.size()), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_lat"}, 64'(obs_lat), 64'(e.lat));
      check({tag, "_resp"}, {62'd0, obs_ack, obs_err}, e.is_err ? 64'd1 : 64'd2);
      if (e.chk_dat) check({tag, "_dat"}, {32'd0, wb_dat_o}, {32'd0, e.dat});
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 60 && busy_o; c++) @(negedge clk_i);
    check(tag, {63'd0, busy_o}, 64'd0);
  endtask

  int a0, a1, w0, w1, r0, r1, k0, e0, t0;
  task automatic snap();
    a0 = aw_cyc[0]; a1 = aw_cyc[1]; w0 = w_cyc[0]; w1 = w_cyc[1];
    r0 = ar_cyc[0]; r1 = ar_cyc[1]; k0 = ack_cnt; e0 = err_cnt; t0 = to_cnt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_ctrl", {50'd0, busy_o, wb_ack_o, wb_err_o, timeout_o, m_axi_awvalid,
          m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 64'd0);
    check("reset_dat", {32'd0, wb_dat_o}, 64'd0);
    rstn_i = 1'b1;

    // Zero-wait write to port 1.
    snap();
    sb.push_back('{1'b0, 3, 1'b0, 32'h0});
    xfer(1'b1, 32'h0001_0004, 32'hDEAD_BEEF, 4'hF);
    sb_check("wr_p1");
    repeat (2) @(negedge clk_i);
    check("wr_p1_awaddr", {32'd0, m_axi_awaddr[63:32]}, 64'h0001_0004);
    check("wr_p1_wdata", {32'd0, m_axi_wdata[63:32]}, 64'hDEAD_BEEF);
    check("wr_p1_wstrb", {60'd0, m_axi_wstrb[7:4]}, 64'hF);
    check("wr_p1_prot", {58'd0, m_axi_awprot}, 64'd0);
    check("wr_p1_valid_cycles", {32'(aw_cyc[1] - a1), 32'(w_cyc[1] - w1)}, {32'd1, 32'd1});
    check("wr_p1_p0_quiet", 64'(aw_cyc[0] - a0 + w_cyc[0] - w0), 64'd0);
    check("wr_p1_one_ack", 64'(ack_cnt - k0), 64'd1);

    // Zero-wait read from port 1.
    rdata_cfg = 32'hCAFE_F00D;
    sb.push_back('{1'b0, 3, 1'b1, 32'hCAFE_F00D});
    xfer(1'b0, 32'h0001_0008, 32'h0, 4'hF);
    sb_check("rd_p1");

    // Read from port 0, data returned a few cycles after the address handshake.
    snap();
    rdata_cfg = 32'h1234_5678; r_dly = 4;
    sb.push_back('{1'b0, 7, 1'b1, 32'h1234_5678});
    xfer(1'b0, 32'h0000_0010, 32'h0, 4'hF);
    sb_check("rd_p0_slow");
    repeat (2) @(negedge clk_i);
    r_dly = 0;
    check("rd_p0_araddr", {32'd0, m_axi_araddr[31:0]}, 64'h10);
    check("rd_p0_p1_quiet", 64'(aw_cyc[1] - a1 + w_cyc[1] - w1 + ar_cyc[1] - r1), 64'd0);
    check("rd_p0_one_ack", 64'(ack_cnt - k0), 64'd1);

    // Unmapped address.
    snap();
    sb.push_back('{1'b1, 1, 1'b0, 32'h0});
    xfer(1'b1, 32'h0002_0000, 32'h1111_1111, 4'hF);
    sb_check("decerr");
    repeat (2) @(negedge clk_i);
    check("decerr_no_axi", 64'(aw_cyc[0] - a0 + aw_cyc[1] - a1 + w_cyc[0] - w0 +
          w_cyc[1] - w1 + ar_cyc[0] - r0 + ar_cyc[1] - r1), 64'd0);
    check("decerr_one_err", 64'(err_cnt - e0), 64'd1);

    // Delayed awready, immediate wready, SLVERR write response; read data must hold.
    snap();
    aw_dly = 3; bresp_cfg = 2'b10;
    sb.push_back('{1'b1, 6, 1'b1, 32'h1234_5678});
    xfer(1'b1, 32'h0000_0100, 32'h0BAD_F00D, 4'h3);
    sb_check("wr_slverr");
    aw_dly = 0; bresp_cfg = 2'b00;
    check("wr_slverr_valid_cycles", {32'(aw_cyc[0] - a0), 32'(w_cyc[0] - w0)}, {32'd4, 32'd1});
    check("wr_slverr_no_ack", 64'(ack_cnt - k0), 64'd0);

    // Timeout on a read whose address is never accepted, then late completion.
    snap();
    ar_dly = 1000; rdata_cfg = 32'hBAD0_BAD0;
    sb.push_back('{1'b1, 17, 1'b0, 32'h0});
    xfer(1'b0, 32'h0000_0020, 32'h0, 4'hF);
    sb_check("timeout");
    check("timeout_pulse", {63'd0, obs_to}, 64'd1);
    repeat (3) @(negedge clk_i);
    check("drain_arvalid_held", {62'd0, m_axi_arvalid}, 64'd1);
    check("drain_busy", {63'd0, busy_o}, 64'd1);
    check("timeout_single", 64'(to_cnt - t0), 64'd1);
    @(posedge clk_i); #1;
    ar_dly = 0;
    wait_idle("drain_exit");
    check("drain_no_ack", {32'(ack_cnt - k0), 32'(err_cnt - e0)}, {32'd0, 32'd1});
    check("drain_dat_kept", {32'd0, wb_dat_o}, 64'h1234_5678);

    // Master drops cyc mid-write: AXI completes, no ack or err.
    snap();
    b_dly = 3;
    @(posedge clk_i); #1;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = 32'h0001_0010; wb_sel_i = 4'hF;
    @(posedge clk_i); #1;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    wait_idle("abort_idle");
    repeat (2) @(negedge clk_i);
    b_dly = 0;
    check("abort_axi_done", 64'(w_cyc[1] - w1), 64'd1);
    check("abort_silent", {32'(ack_cnt - k0), 32'(err_cnt - e0)}, 64'd0);

    // Reset while waiting for a write response.
    b_dly = 100;
    @(posedge clk_i); #1;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = 32'h0000_0040; wb_dat_i = 32'h77;
    repeat (4) @(negedge clk_i);
    check("pre_reset_wresp", {62'd0, m_axi_bready}, 64'd1);
    #1 rstn_i = 1'b0;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    #1;
    check("midrst_ctrl", {50'd0, busy_o, wb_ack_o, wb_err_o, timeout_o, m_axi_awvalid,
          m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 64'd0);
    check("midrst_dat", {32'd0, wb_dat_o}, 64'd0);
    check("midrst_addr", m_axi_awaddr | {m_axi_wdata[63:32], m_axi_wdata[31:0]}, 64'd0);
    @(negedge clk_i);
    rstn_i = 1'b1; b_dly = 0;
    rdata_cfg = 32'h5A5A_5A5A;
    sb.push_back('{1'b0, 3, 1'b1, 32'h5A5A_5A5A});
    xfer(1'b0, 32'h0001_0000, 32'h0, 4'hF);
    sb_check("post_reset_rd");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
